// File: rtl/huffman_bit_packer_if.sv
// Codeword input stream and packed-word output stream of the Huffman bit packer.
// The master side feeds codes and sinks words; the slave side is the packer.
interface huffman_bit_packer_if #(
  parameter int WORD_W = 32,
  parameter int CODE_W = 9,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
);
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code_bits;
  logic [LEN_W-1:0]  code_len;
  logic              code_last;
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;
  logic [5:0]        word_bits;
  logic              word_last;
  logic [CNT_W-1:0]  total_bits;

  modport master (
    output code_valid, code_bits, code_len, code_last, word_ready,
    input  code_ready, word_valid, word_data, word_bits, word_last, total_bits
  );

  modport slave (
    input  code_valid, code_bits, code_len, code_last, word_ready,
    output code_ready, word_valid, word_data, word_bits, word_last, total_bits
  );
endinterface

// File: rtl/huffman_bit_packer.sv
// Packs MSB-first variable-length codewords into WORD_W-bit words, flushing a
// zero-padded final word at the end of each packet.
module huffman_bit_packer #(
  parameter int WORD_W = 32,
  parameter int CODE_W = 9,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  huffman_bit_packer_if.slave    bus
);
  localparam int ACC_W = WORD_W + CODE_W;
  localparam int CW    = $clog2(ACC_W);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CW-1:0]     cnt_q;
  logic [CNT_W-1:0]  total_q;
  logic              first_q;

  logic [LEN_W-1:0]  len_eff;
  logic [CODE_W-1:0] code_mask;
  logic [CODE_W-1:0] code_left;
  logic [ACC_W-1:0]  code_ext;
  logic [CNT_W:0]    total_sum;
  logic [CNT_W-1:0]  total_d;
  logic              word_valid;
  logic              word_last;
  logic              code_ready;
  logic              accept;
  logic              emit;

  // NOTE: every always_comb output gets a value on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    len_eff    = (bus.code_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : bus.code_len;
    code_mask  = bus.code_bits & ~({CODE_W{1'b1}} << len_eff);
    // Left-align the code so its first bit lands at accumulator position cnt.
    code_left  = code_mask << (LEN_W'(CODE_W) - len_eff);
    code_ext   = {code_left, {WORD_W{1'b0}}} >> cnt_q;

    total_sum  = {1'b0, total_q} + (CNT_W+1)'(len_eff);
    if (first_q)
      total_d = CNT_W'(len_eff);
    else if (total_sum[CNT_W])
      total_d = '1;
    else
      total_d = total_sum[CNT_W-1:0];

    word_valid = (state_q == FLUSH) || (cnt_q >= CW'(WORD_W));
    word_last  = (state_q == FLUSH) && (cnt_q <= CW'(WORD_W));
    code_ready = (state_q == RUN) && (cnt_q < CW'(WORD_W));
    accept     = bus.code_valid && code_ready;
    emit       = word_valid && bus.word_ready;
  end

  assign bus.code_ready = code_ready;
  assign bus.word_valid = word_valid;
  assign bus.word_last  = word_last;
  assign bus.word_data  = acc_q[ACC_W-1 -: WORD_W];
  assign bus.word_bits  = !word_valid ? 6'd0 : (word_last ? 6'(cnt_q) : 6'(WORD_W));
  assign bus.total_bits = total_q;

  // Accept and emit are mutually exclusive: code_ready needs cnt < WORD_W in
  // RUN, while a RUN-state word needs cnt >= WORD_W.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      first_q <= 1'b1;
    end else if (accept) begin
      acc_q   <= acc_q | code_ext;
      cnt_q   <= cnt_q + CW'(len_eff);
      total_q <= total_d;
      first_q <= bus.code_last;
      if (bus.code_last) state_q <= FLUSH;
    end else if (emit) begin
      if (word_last) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= RUN;
      end else begin
        acc_q   <= acc_q << WORD_W;
        cnt_q   <= cnt_q - CW'(WORD_W);
      end
    end
  end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench: a bit-queue model of the packer checked every cycle,
// directed packets with literal word expectations, then randomized packets.
module tb_huffman_bit_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  huffman_bit_packer_if #(.WORD_W(32), .CODE_W(9), .LEN_W(4), .CNT_W(16)) bus ();

  huffman_bit_packer #(.WORD_W(32), .CODE_W(9), .LEN_W(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending bits as a queue, first bit at index 0.
  bit          mq[$];
  bit          mflush = 1'b0;
  bit          mfirst = 1'b1;
  int          mtotal = 0;

  logic [31:0] log_data[$];
  int          log_bits[$];
  bit          log_last[$];

  int          rdy_mode = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        mflush = 1'b0;
        mfirst = 1'b1;
        mtotal = 0;
      end else begin
        bit          exp_ready, exp_valid, exp_last;
        int          exp_bits;
        logic [31:0] exp_data;
        exp_ready = !mflush && (mq.size() < 32);
        exp_valid = mflush || (mq.size() >= 32);
        exp_last  = mflush && (mq.size() <= 32);
        exp_bits  = exp_last ? mq.size() : 32;
        exp_data  = '0;
        for (int i = 0; i < 32; i++)
          if (i < mq.size()) exp_data[31-i] = mq[i];
        check("code_ready", 64'(bus.code_ready), 64'(exp_ready));
        check("word_valid", 64'(bus.word_valid), 64'(exp_valid));
        check("total_bits", 64'(bus.total_bits), 64'(mtotal));
        if (exp_valid) begin
          check("word_data", 64'(bus.word_data), 64'(exp_data));
          check("word_bits", 64'(bus.word_bits), 64'(exp_bits));
          check("word_last", 64'(bus.word_last), 64'(exp_last));
          if (bus.word_ready) begin
            log_data.push_back(bus.word_data);
            log_bits.push_back(int'(bus.word_bits));
            log_last.push_back(bus.word_last);
            for (int i = 0; i < 32 && mq.size() > 0; i++) void'(mq.pop_front());
            if (exp_last) mflush = 1'b0;
          end
        end
        if (bus.code_valid && exp_ready) begin
          int le;
          le = (int'(bus.code_len) > 9) ? 9 : int'(bus.code_len);
          for (int i = le - 1; i >= 0; i--) mq.push_back(bus.code_bits[i]);
          mtotal = mfirst ? le : ((mtotal + le > 65535) ? 65535 : mtotal + le);
          mfirst = bus.code_last;
          if (bus.code_last) mflush = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.word_ready = 1'b1;
        1:       bus.word_ready = 1'($urandom_range(0, 1));
        default: bus.word_ready = 1'b0;
      endcase
    end
  end

  // Callers sit just after a rising edge; returns just after the accepting edge.
  task automatic send_code(input logic [8:0] b, input logic [3:0] l, input logic last);
    int   n;
    logic took;
    n    = 0;
    took = 1'b0;
    bus.code_valid = 1'b1;
    bus.code_bits  = b;
    bus.code_len   = l;
    bus.code_last  = last;
    while (!took && n < 300) begin
      @(negedge clk);
      took = bus.code_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) check("send_timeout", 64'(took), 64'd1);
    bus.code_valid = 1'b0;
    bus.code_bits  = 9'($urandom);
    bus.code_len   = 4'($urandom);
    bus.code_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mflush || mq.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mflush || mq.size() != 0) check("drain_timeout", 64'(mq.size()), 64'd0);
  endtask

  task automatic check_log(input int idx, input logic [31:0] d, input int b, input bit l);
    if (idx < log_data.size()) begin
      check("log_data", 64'(log_data[idx]), 64'(d));
      check("log_bits", 64'(log_bits[idx]), 64'(b));
      check("log_last", 64'(log_last[idx]), 64'(l));
    end else begin
      check("log_present", 64'(log_data.size()), 64'(idx + 1));
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_bits.delete();
    log_last.delete();
  endtask

  initial begin
    bus.code_valid = 1'b0;
    bus.code_bits  = '0;
    bus.code_len   = '0;
    bus.code_last  = 1'b0;
    bus.word_ready = 1'b1;
    #1;
    check("rst_word_valid", 64'(bus.word_valid), 64'd0);
    check("rst_word_data", 64'(bus.word_data), 64'd0);
    check("rst_word_bits", 64'(bus.word_bits), 64'd0);
    check("rst_total_bits", 64'(bus.total_bits), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_code_ready", 64'(bus.code_ready), 64'd1);

    // Ten 3-bit codes 101 -> one 30-bit final word.
    clear_log();
    for (int i = 0; i < 10; i++) send_code(9'h005, 4'd3, i == 9);
    wait_idle();
    check("t1_words", 64'(log_data.size()), 64'd1);
    check_log(0, 32'hB6DB6DB4, 30, 1'b1);
    check("t1_total", 64'(bus.total_bits), 64'd30);

    // Four 9-bit all-ones codes -> full word then 4-bit tail.
    clear_log();
    for (int i = 0; i < 4; i++) send_code(9'h1FF, 4'd9, i == 3);
    wait_idle();
    check("t2_words", 64'(log_data.size()), 64'd2);
    check_log(0, 32'hFFFFFFFF, 32, 1'b0);
    check_log(1, 32'hF0000000, 4, 1'b1);
    check("t2_total", 64'(bus.total_bits), 64'd36);

    // Exactly WORD_W bits -> a single full last word, nothing after it.
    clear_log();
    for (int i = 0; i < 8; i++) send_code(9'h00A, 4'd4, i == 7);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("t3_words", 64'(log_data.size()), 64'd1);
    check_log(0, 32'hAAAAAAAA, 32, 1'b1);

    // Masking of bits above code_len and a zero-length code.
    clear_log();
    send_code(9'h1FF, 4'd2, 1'b0);
    send_code(9'h0FF, 4'd0, 1'b0);
    send_code(9'h001, 4'd1, 1'b1);
    wait_idle();
    check("t4_words", 64'(log_data.size()), 64'd1);
    check_log(0, 32'hE0000000, 3, 1'b1);
    check("t4_total", 64'(bus.total_bits), 64'd3);

    // Empty packet.
    clear_log();
    send_code(9'h1FF, 4'd0, 1'b1);
    wait_idle();
    check("t5_words", 64'(log_data.size()), 64'd1);
    check_log(0, 32'h00000000, 0, 1'b1);

    // Backpressure on a pending full word.
    clear_log();
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) send_code(9'h00A, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_word_valid", 64'(bus.word_valid), 64'd1);
      check("bp_word_data", 64'(bus.word_data), 64'hAAAAAAAA);
      check("bp_code_ready", 64'(bus.code_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_code(9'h155, 4'd9, 1'b1);
    wait_idle();
    check("t6_words", 64'(log_data.size()), 64'd2);
    check_log(0, 32'hAAAAAAAA, 32, 1'b0);
    check_log(1, 32'hAA800000, 9, 1'b1);

    // Asynchronous reset after 20 bits, then a fresh packet.
    for (int i = 0; i < 5; i++) send_code(9'h00F, 4'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_word_valid", 64'(bus.word_valid), 64'd0);
    check("mid_rst_word_data", 64'(bus.word_data), 64'd0);
    check("mid_rst_word_bits", 64'(bus.word_bits), 64'd0);
    check("mid_rst_word_last", 64'(bus.word_last), 64'd0);
    check("mid_rst_total", 64'(bus.total_bits), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_code_ready", 64'(bus.code_ready), 64'd1);
    clear_log();
    send_code(9'h155, 4'd9, 1'b1);
    wait_idle();
    check("t7_words", 64'(log_data.size()), 64'd1);
    check_log(0, 32'hAA800000, 9, 1'b1);
    check("t7_total", 64'(bus.total_bits), 64'd9);

    // Randomized packets with random gaps and random sink backpressure.
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int ncodes;
      ncodes = $urandom_range(1, 25);
      for (int c = 0; c < ncodes; c++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_code(9'($urandom), 4'($urandom_range(0, 11)), c == ncodes - 1);
      end
      wait_idle();
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
